ps2_host_transmitter: RTL and testbench

PS2_HOST_TRANSMITTER -- requirements
Module: ps2_host_transmitter

---
 rtl/ps2_host_transmitter.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// one command byte (LSB first, odd parity, stop) on device clock edges and checks the ACK.
module ps2_host_transmitter #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       FCLK,
  input  logic       RST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_DRV_LOW,
  output logic       PS2_DATA_DRV_LOW,
  output logic       BUSY,
  output logic       TX_DONE,
  output logic       TX_ERROR
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQUEST   = 3'd2,
    S_SEND      = 3'd3,
    S_STOP      = 3'd4,
    S_ACK       = 3'd5,
    S_WAIT_IDLE = 3'd6
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t        state_q, state_d;
  logic [8:0]    frame_q, frame_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ack_q, ack_d;
  logic          clk_s1_q, clk_s2_q, clk_s3_q;
  logic          data_s1_q, data_s2_q;
  logic          clk_drv_q, clk_drv_d;
  logic          data_drv_q, data_drv_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          fall_s, wait_s, timeout_s, complete_s;

  assign fall_s = clk_s3_q & ~clk_s2_q;
  assign wait_s = (state_q == S_REQUEST) || (state_q == S_SEND) || (state_q == S_STOP) ||
                  (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign timeout_s  = wait_s && (to_cnt_q == TO_LAST) && !fall_s;
  assign complete_s = (state_q == S_WAIT_IDLE) && clk_s2_q && data_s2_q;

  // Synchronizers idle high so reset never manufactures a falling edge.
  always_ff @(posedge FCLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      frame_q    <= 9'd0;
      bit_cnt_q  <= 4'd0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      ack_q      <= 1'b0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_s3_q   <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      ack_q      <= ack_d;
      clk_s1_q   <= PS2_CLK_IN;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
      data_s1_q  <= PS2_DATA_IN;
      data_s2_q  <= data_s1_q;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    ack_d     = ack_q;
    if (wait_s) begin
      to_cnt_d = fall_s ? '0 : to_cnt_q + TW'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
    case (state_q)
      S_IDLE: begin
        if (TX_START) begin
          frame_d   = {odd_parity(TX_DATA), TX_DATA};
          bit_cnt_d = 4'd0;
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          ack_d     = 1'b0;
          state_d   = S_INHIBIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          to_cnt_d = '0;
          state_d  = S_REQUEST;
        end else begin
          inh_cnt_d = inh_cnt_q + IW'(1);
        end
      end
      S_REQUEST: begin
        if (fall_s) begin
          bit_cnt_d = 4'd0;
          state_d   = S_SEND;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQUEST;
        end
      end
      S_SEND: begin
        if (fall_s) begin
          if (bit_cnt_q == 4'd8) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      S_STOP: begin
        if (fall_s) begin
          ack_d   = ~data_s2_q;
          state_d = S_ACK;
        end else if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      S_ACK: begin
        if (timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (complete_s || timeout_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every pad drive comes straight off a flop.
  always_comb begin
    clk_drv_d = (state_d == S_INHIBIT);
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_REQUEST: data_drv_d = 1'b1;
      S_SEND:    data_drv_d = ~frame_d[bit_cnt_d];
      default:   data_drv_d = 1'b0;
    endcase
    if (complete_s) begin
      done_d = ack_q;
      err_d  = ~ack_q;
    end else begin
      done_d = 1'b0;
      err_d  = timeout_s;
    end
  end

  assign PS2_CLK_DRV_LOW  = clk_drv_q;
  assign PS2_DATA_DRV_LOW = data_drv_q;
  assign BUSY             = busy_q;
  assign TX_DONE          = done_q;
  assign TX_ERROR         = err_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench: a PS/2 device model clocks frames out of the host and compares
// every presented bit, the inhibit length, timeout latency and status pulses with a reference.
module tb_ps2_host_transmitter;
  localparam int INH  = 5000;
  localparam int TO   = 2000;
  localparam int HALF = 15;

  logic       FCLK = 1'b0;
  logic       RST;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       dev_clk, dev_data;
  logic       PS2_CLK_IN, PS2_DATA_IN;
  logic       PS2_CLK_DRV_LOW, PS2_DATA_DRV_LOW, BUSY, TX_DONE, TX_ERROR;
  int         errors = 0;
  int         checks = 0;

  // Open-drain wired-AND of host and device on both lines.
  assign PS2_CLK_IN  = dev_clk & ~PS2_CLK_DRV_LOW;
  assign PS2_DATA_IN = dev_data & ~PS2_DATA_DRV_LOW;

  always #5 FCLK = ~FCLK;

  ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .FCLK(FCLK), .RST(RST), .TX_DATA(TX_DATA), .TX_START(TX_START),
    .PS2_CLK_IN(PS2_CLK_IN), .PS2_DATA_IN(PS2_DATA_IN),
    .PS2_CLK_DRV_LOW(PS2_CLK_DRV_LOW), .PS2_DATA_DRV_LOW(PS2_DATA_DRV_LOW),
    .BUSY(BUSY), .TX_DONE(TX_DONE), .TX_ERROR(TX_ERROR)
  );

  task automatic tick();
    @(posedge FCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bits in wire order: data LSB first, then a parity bit making the ones count odd.
  function automatic logic [8:0] ref_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic start_frame(input logic [7:0] d, input bit extra_start);
    int n;
    TX_DATA  = d;
    TX_START = 1'b1;
    tick();
    TX_START = 1'b0;
    check("start_busy", BUSY, 1);
    check("inhibit_clk", PS2_CLK_DRV_LOW, 1);
    TX_DATA = 8'($urandom);
    n = 1;
    for (int i = 0; i < INH + 100; i++) begin
      TX_START = (extra_start && i == 10) ? 1'b1 : 1'b0;
      tick();
      if (PS2_CLK_DRV_LOW) n++;
      else break;
    end
    TX_START = 1'b0;
    check("inhibit_len", n, INH);
    check("req_clk_rel", PS2_CLK_DRV_LOW, 0);
    check("req_data_low", PS2_DATA_DRV_LOW, 1);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input int rst_edge, input bit extra_start);
    logic [8:0] exp;
    int dn, er, both;
    exp = ref_frame(d);
    start_frame(d, extra_start);
    repeat (10) tick();
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) tick();
      if (e <= 9) check($sformatf("bit%0d_of_%0h", e - 1, d), PS2_DATA_IN, exp[e-1]);
      else if (e == 10) check("stop_bit", PS2_DATA_IN, 1);
      if (e == rst_edge) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_clk_drv", PS2_CLK_DRV_LOW, 0);
        check("rst_data_drv", PS2_DATA_DRV_LOW, 0);
        check("rst_busy", BUSY, 0);
        dev_clk = 1'b1;
        dn = 0;
        er = 0;
        repeat (30) begin
          tick();
          dn += int'(TX_DONE);
          er += int'(TX_ERROR);
        end
        check("rst_no_done", dn, 0);
        check("rst_no_error", er, 0);
        return;
      end
      dev_data = 1'b1;
      dev_clk  = 1'b1;
      if (e < 11) repeat (HALF) tick();
    end
    dn = 0;
    er = 0;
    both = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      dn += int'(TX_DONE);
      er += int'(TX_ERROR);
      if (TX_DONE && TX_ERROR) both++;
    end
    check("done_pulses", dn, ack ? 1 : 0);
    check("error_pulses", er, ack ? 0 : 1);
    check("done_err_same_cycle", both, 0);
    check("end_busy", BUSY, 0);
    check("end_drives", {PS2_CLK_DRV_LOW, PS2_DATA_DRV_LOW}, 0);
  endtask

  initial begin
    int k;
    RST      = 1'b1;
    TX_START = 1'b0;
    TX_DATA  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) tick();
    check("rst_state", {PS2_CLK_DRV_LOW, PS2_DATA_DRV_LOW, BUSY, TX_DONE, TX_ERROR}, 0);
    RST = 1'b0;
    tick();

    run_frame(8'hED, 1'b1, 0, 1'b1);
    run_frame(8'h00, 1'b1, 0, 1'b0);
    run_frame(8'h01, 1'b1, 0, 1'b0);
    run_frame(8'($urandom), 1'b0, 0, 1'b0);
    repeat (2) run_frame(8'($urandom), 1'($urandom), 0, 1'b0);

    // Device never answers the request.
    start_frame(8'($urandom), 1'b0);
    k = 0;
    for (int i = 0; i < TO + 50; i++) begin
      tick();
      k++;
      if (TX_ERROR) break;
    end
    check("timeout_latency", k, TO);
    check("timeout_drives", {PS2_CLK_DRV_LOW, PS2_DATA_DRV_LOW}, 0);
    check("timeout_no_done", TX_DONE, 0);
    tick();
    check("timeout_err_one_cycle", TX_ERROR, 0);
    check("timeout_idle", BUSY, 0);

    run_frame(8'($urandom), 1'b1, 5, 1'b0);
    run_frame(8'($urandom), 1'b1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
